bank_isu_gen: RTL and testbench
===============================

# bank_isu_gen

Parametrised request generator that drives the bank issue → storage-controller (SC) request channel. It issues a programmable burst of read, write or alternating write/read requests over the full valid/ready handshake. Channel IDs rotate round-robin and set/way/offset and linefill payloads follow a deterministic pattern. It sits where the bank ISU front end connects to SC and serves as the bring-up and stress source for SC and downstream datapaths.

## Interface
- NUM_CH, 4: number of SC channels; CH_W = max(1, $clog2(NUM_CH))
- SWO_W, 7: set/way/offset width
- DATA_W, 128: linefill data width per offset
- WBUF_W, 8: write-buffer ID width
- ROB_W, 3: xbar ROB number width
- SWO_STRIDE, 2: set/way/offset increment per advance
- DATA_STEP, 100: linefill data increment per advance
- clk_i  in  1  clock; single clock domain
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start a burst (sampled in IDLE only)
- mode_i  in  2  0 = write, 1 = read, 2 = alternate write/read, 3 = reserved (treated as read)
- num_req_i  in  16  number of handshakes in the burst
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse at burst end
- isu_sc_valid_o  out  1  request valid
- isu_sc_ready_i  in  1  SC accepts request
- isu_sc_channel_id_o  out  CH_W  target channel
- isu_sc_opcode_o  out  3  0 = write, 1 = read
- isu_sc_set_way_offset_o  out  SWO_W  line location
- isu_sc_wbuffer_id_o  out  WBUF_W  write-buffer ID
- isu_sc_xbar_rob_num_o  out  ROB_W  ROB tag
- isu_sc_cacheline_dirty_offset0_o / _offset1_o  out  2 each  dirty marks
- isu_sc_linefill_data_offset0_o / _offset1_o  out  DATA_W each  linefill data

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN: on start_i with num_req_i ≠ 0. mode_i and num_req_i are latched at this point.
  - IDLE → DONE: on start_i with num_req_i = 0. No request is issued.
  - RUN → DONE: on the handshake that makes the issued count equal num_req.
  - DONE → IDLE: unconditionally.
- start_i is ignored outside IDLE. Mode and count inputs may change freely during RUN.
- busy_o = (state ≠ IDLE). done_o = (state == DONE).
- isu_sc_valid_o = (state == RUN). The payload is held stable while valid && !ready.
- A handshake is valid && ready. On each handshake, issued count increments.
- Advance rule: channel, SWO and data advance on every handshake in modes 0/1. In mode 2 they advance only on the read (second) handshake, so each write and read pair targets the same channel/SWO/data.
- Opcode: mode 0 → 0; mode 1/3 → 1; mode 2 → 0 on even issued count, 1 on odd. An odd num_req in mode 2 ends on a write.
- Channel increments modulo NUM_CH.
- SWO += SWO_STRIDE, modulo 2^SWO_W.
- data0 += DATA_STEP, modulo 2^DATA_W. data1 = data0 + 1, modulo 2^DATA_W.
- xbar_rob_num = issued count[ROB_W-1:0].
- wbuffer_id = issued count[WBUF_W-1:0] for writes, 0 for reads.
- Dirty offsets: 2'b11 on writes, 2'b00 on reads.
- Channel, SWO, data and count restart from 0 at every start.
- Reset values: all outputs 0. state = IDLE, all counters 0.
- Reset mid-burst: valid drops asynchronously and the burst is abandoned; no done_o pulse.

## Timing
- valid rises the cycle after start_i is sampled.
- Sustained throughput is one request per cycle with ready held high.
- Next payload is visible the cycle after a handshake.
- done_o pulses the cycle after the final handshake. A new start_i is accepted two cycles after the final handshake (IDLE).
- No combinational path from isu_sc_ready_i to any output.

## Configuration
- BANK_ISU_GEN_LFSR_EN defined:
  - data0 comes from a 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1), seed 32'h1 at start, replicated to DATA_W.
  - The LFSR steps under the same advance rule.
  - data1 = ~data0.
- Undefined: incrementing pattern as described above; LFSR logic is absent.

## Structure
- bank_isu_pkg holds the opcode constants (OP_WRITE = 0, OP_READ = 1), the mode enum, the FSM state enum and the LFSR seed/taps.
- One sub-module, bank_isu_lfsr, instantiated only under BANK_ISU_GEN_LFSR_EN.

## Test plan
- Mode 1, num_req = 3, NUM_CH = 4, ready held high:
  - Three consecutive handshakes: channel 0/1/2, SWO 0/2/4, data0 0/100/200, data1 1/101/201, opcode 1, rob 0/1/2.
  - done_o pulses one cycle after the third handshake.
- Mode 1, num_req = 2, ready low for 3 cycles after valid rises: payload unchanged (channel 0, SWO 0, data0 0) across the stall.
- Mode 2, num_req = 4:
  - opcode 0/1/0/1, channel 0/0/1/1, SWO 0/0/2/2.
  - wbuffer_id 0/0/2/0, dirty 3/0/3/0.
- Mode 0, num_req = 65: handshake 65 shows SWO 0 (wrap at 2^7) and channel 0; all handshakes have opcode 0 and dirty 2'b11.
- num_req = 0: no valid; done_o pulses one cycle after start; start_i pulses during RUN are ignored.
- Reset mid-burst after 2 of 5 handshakes: valid low immediately, no done_o; after reset release a restart begins at SWO 0, channel 0.

Source files
------------

// File: rtl/bank_isu_pkg.sv
// bank_isu_pkg: shared constants and types for the bank ISU -> SC request
// generator (opcodes, burst modes, FSM states, LFSR seed/taps).
package bank_isu_pkg;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;

  typedef enum logic [1:0] {
    MODE_WR   = 2'd0,
    MODE_RD   = 2'd1,
    MODE_ALT  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // x^32 + x^22 + x^2 + x + 1 -> feedback from bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/bank_isu_lfsr.sv
// bank_isu_lfsr: 32-bit Fibonacci LFSR used as the linefill data source
// when BANK_ISU_GEN_LFSR_EN is defined.
// Ports: clk_i, rst_n_i (async active-low), load_i (reload seed),
//        step_i (advance one step), state_o (current LFSR value).
module bank_isu_lfsr
  import bank_isu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = LFSR_SEED;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[30:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/bank_isu_gen.sv
// bank_isu_gen: programmable burst request generator on the bank ISU -> SC
// valid/ready request channel (write, read or alternating write/read).
// Ports: clk_i, rst_n_i (async active-low); start_i/mode_i/num_req_i burst
//        control; busy_o/done_o status; isu_sc_* request channel.
// Optional: BANK_ISU_GEN_LFSR_EN selects LFSR linefill data (data1 = ~data0)
//        instead of the incrementing pattern (data1 = data0 + 1).
//
// state | meaning
// IDLE  | waiting for start_i; mode and count latched on start
// RUN   | valid high, issuing requests until num_req handshakes
// DONE  | one-cycle done_o pulse, then back to IDLE
module bank_isu_gen
  import bank_isu_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SWO_W      = 7,
  parameter int DATA_W     = 128,
  parameter int WBUF_W     = 8,
  parameter int ROB_W      = 3,
  parameter int SWO_STRIDE = 2,
  parameter int DATA_STEP  = 100,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [15:0]       num_req_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              isu_sc_valid_o,
  input  logic              isu_sc_ready_i,
  output logic [CH_W-1:0]   isu_sc_channel_id_o,
  output logic [2:0]        isu_sc_opcode_o,
  output logic [SWO_W-1:0]  isu_sc_set_way_offset_o,
  output logic [WBUF_W-1:0] isu_sc_wbuffer_id_o,
  output logic [ROB_W-1:0]  isu_sc_xbar_rob_num_o,
  output logic [1:0]        isu_sc_cacheline_dirty_offset0_o,
  output logic [1:0]        isu_sc_cacheline_dirty_offset1_o,
  output logic [DATA_W-1:0] isu_sc_linefill_data_offset0_o,
  output logic [DATA_W-1:0] isu_sc_linefill_data_offset1_o
);

  state_e           state_q;
  mode_e            mode_q;
  logic [15:0]      num_q, cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [SWO_W-1:0] swo_q;
  logic             vld, hs, adv, is_wr, start_ok;
  logic [DATA_W-1:0] data0, data1;

  assign vld      = (state_q == ST_RUN);
  assign hs       = vld && isu_sc_ready_i;
  assign start_ok = (state_q == ST_IDLE) && start_i;
  // Alternate mode: the write and its following read share one location,
  // so the pattern only moves on after the read (odd count).
  assign adv      = hs && ((mode_q != MODE_ALT) || cnt_q[0]);
  assign is_wr    = (mode_q == MODE_WR) || ((mode_q == MODE_ALT) && !cnt_q[0]);
  assign cnt_d    = cnt_q + 16'd1;
  assign ch_d     = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_WR;
      num_q   <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      swo_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mode_q  <= mode_e'(mode_i);
            num_q   <= num_req_i;
            cnt_q   <= '0;
            ch_q    <= '0;
            swo_q   <= '0;
            state_q <= (num_req_i == 16'd0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (hs) begin
            cnt_q <= cnt_d;
            if (adv) begin
              ch_q  <= ch_d;
              swo_q <= swo_q + SWO_W'(SWO_STRIDE);
            end
            if (cnt_d == num_q) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BANK_ISU_GEN_LFSR_EN
  logic [31:0] lfsr;

  bank_isu_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (start_ok),
    .step_i  (adv),
    .state_o (lfsr)
  );

  always_comb begin
    data0 = '0;
    for (int i = 0; i < DATA_W; i++) data0[i] = lfsr[i % 32];
  end
  assign data1 = ~data0;
`else
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
    end else if (start_ok) begin
      data_q <= '0;
    end else if (adv) begin
      data_q <= data_q + DATA_W'(DATA_STEP);
    end
  end

  assign data0 = data_q;
  assign data1 = data_q + DATA_W'(1);
`endif

  // Payload is forced to zero outside RUN so every output reads 0 in reset/idle.
  assign busy_o                           = (state_q != ST_IDLE);
  assign done_o                           = (state_q == ST_DONE);
  assign isu_sc_valid_o                   = vld;
  assign isu_sc_channel_id_o              = vld ? ch_q : '0;
  assign isu_sc_opcode_o                  = !vld ? 3'd0 : (is_wr ? OP_WRITE : OP_READ);
  assign isu_sc_set_way_offset_o          = vld ? swo_q : '0;
  assign isu_sc_wbuffer_id_o              = (vld && is_wr) ? cnt_q[WBUF_W-1:0] : '0;
  assign isu_sc_xbar_rob_num_o            = vld ? cnt_q[ROB_W-1:0] : '0;
  assign isu_sc_cacheline_dirty_offset0_o = (vld && is_wr) ? 2'b11 : 2'b00;
  assign isu_sc_cacheline_dirty_offset1_o = (vld && is_wr) ? 2'b11 : 2'b00;
  assign isu_sc_linefill_data_offset0_o   = vld ? data0 : '0;
  assign isu_sc_linefill_data_offset1_o   = vld ? data1 : '0;

endmodule

// File: tb/tb_bank_isu_gen.sv
module tb_bank_isu_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [15:0]  num_req;
  logic         busy, done, valid, ready;
  logic [1:0]   ch;
  logic [2:0]   op;
  logic [6:0]   swo;
  logic [7:0]   wbuf;
  logic [2:0]   rob;
  logic [1:0]   dirty0, dirty1;
  logic [127:0] d0, d1;

  bank_isu_gen dut (
    .clk_i                            (clk),
    .rst_n_i                          (rst_n),
    .start_i                          (start),
    .mode_i                           (mode),
    .num_req_i                        (num_req),
    .busy_o                           (busy),
    .done_o                           (done),
    .isu_sc_valid_o                   (valid),
    .isu_sc_ready_i                   (ready),
    .isu_sc_channel_id_o              (ch),
    .isu_sc_opcode_o                  (op),
    .isu_sc_set_way_offset_o          (swo),
    .isu_sc_wbuffer_id_o              (wbuf),
    .isu_sc_xbar_rob_num_o            (rob),
    .isu_sc_cacheline_dirty_offset0_o (dirty0),
    .isu_sc_cacheline_dirty_offset1_o (dirty1),
    .isu_sc_linefill_data_offset0_o   (d0),
    .isu_sc_linefill_data_offset1_o   (d1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [1:0]   ch;
    logic [2:0]   op;
    logic [6:0]   swo;
    logic [7:0]   wbuf;
    logic [2:0]   rob;
    logic [1:0]   dirty0;
    logic [1:0]   dirty1;
    logic [127:0] d0;
    logic [127:0] d1;
  } hs_t;

  hs_t hs_q[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  start_cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;

  int exp_op[4]  = '{0, 1, 0, 1};
  int exp_ch[4]  = '{0, 0, 1, 1};
  int exp_swo[4] = '{0, 0, 2, 2};
  int exp_wb[4]  = '{0, 0, 2, 0};
  int exp_dt[4]  = '{3, 0, 3, 0};

  always @(posedge clk) cyc++;

  // Inputs change #1 after posedge, so at negedge valid&&ready means the
  // handshake completes on the coming posedge.
  always @(negedge clk) begin
    hs_t h;
    if (valid && ready) begin
      h.cyc = cyc; h.ch = ch; h.op = op; h.swo = swo; h.wbuf = wbuf; h.rob = rob;
      h.dirty0 = dirty0; h.dirty1 = dirty1; h.d0 = d0; h.d1 = d1;
      hs_q.push_back(h);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_burst(input logic [1:0] m, input logic [15:0] n);
    hs_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    mode      = m;
    num_req   = n;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin
      tick();
      i++;
    end
    chk(tag, (done_cnt != 0), 1'b1);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; num_req = 16'd0; ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_d1", d1, 0);
    rst_n = 1'b1;
    tick();

    // Read burst of 3, ready held high
    ready = 1'b1;
    start_burst(2'd1, 16'd3);
    wait_done("t1_done_seen", 20);
    chk("t1_count", hs_q.size(), 3);
    chk("t1_first_cyc", (hs_q.size() > 0) ? hs_q[0].cyc : -1, start_cyc + 1);
    for (int i = 0; i < hs_q.size(); i++) begin
      chk($sformatf("t1_ch%0d", i), hs_q[i].ch, i);
      chk($sformatf("t1_swo%0d", i), hs_q[i].swo, 2 * i);
      chk($sformatf("t1_d0_%0d", i), hs_q[i].d0, 100 * i);
      chk($sformatf("t1_d1_%0d", i), hs_q[i].d1, 100 * i + 1);
      chk($sformatf("t1_op%0d", i), hs_q[i].op, 1);
      chk($sformatf("t1_rob%0d", i), hs_q[i].rob, i);
      chk($sformatf("t1_cyc%0d", i), hs_q[i].cyc, start_cyc + 1 + i);
    end
    chk("t1_done_cyc", done_cyc, start_cyc + 4);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_idle", busy, 0);

    // Stall: ready low for 3 cycles once valid is up
    ready = 1'b0;
    start_burst(2'd1, 16'd2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_valid%0d", i), valid, 1);
      chk($sformatf("t2_ch%0d", i), ch, 0);
      chk($sformatf("t2_swo%0d", i), swo, 0);
      chk($sformatf("t2_d0_%0d", i), d0, 0);
      if (i < 2) tick();
    end
    ready = 1'b1;
    wait_done("t2_done_seen", 20);
    chk("t2_count", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      chk("t2_hs0_ch", hs_q[0].ch, 0);
      chk("t2_hs1_ch", hs_q[1].ch, 1);
      chk("t2_hs1_swo", hs_q[1].swo, 2);
      chk("t2_hs1_d0", hs_q[1].d0, 100);
    end

    // Alternating write/read, 4 requests
    start_burst(2'd2, 16'd4);
    wait_done("t3_done_seen", 20);
    chk("t3_count", hs_q.size(), 4);
    for (int i = 0; i < hs_q.size() && i < 4; i++) begin
      chk($sformatf("t3_op%0d", i), hs_q[i].op, exp_op[i]);
      chk($sformatf("t3_ch%0d", i), hs_q[i].ch, exp_ch[i]);
      chk($sformatf("t3_swo%0d", i), hs_q[i].swo, exp_swo[i]);
      chk($sformatf("t3_wbuf%0d", i), hs_q[i].wbuf, exp_wb[i]);
      chk($sformatf("t3_dirty0_%0d", i), hs_q[i].dirty0, exp_dt[i]);
      chk($sformatf("t3_dirty1_%0d", i), hs_q[i].dirty1, exp_dt[i]);
      chk($sformatf("t3_d0_%0d", i), hs_q[i].d0, 100 * exp_ch[i]);
    end

    // Writes, 65 requests: SWO wraps at 128
    start_burst(2'd0, 16'd65);
    wait_done("t4_done_seen", 200);
    chk("t4_count", hs_q.size(), 65);
    if (hs_q.size() == 65) begin
      chk("t4_swo64", hs_q[64].swo, 0);
      chk("t4_ch64", hs_q[64].ch, 0);
      chk("t4_swo63", hs_q[63].swo, 126);
      chk("t4_rob64", hs_q[64].rob, 0);
      chk("t4_wbuf64", hs_q[64].wbuf, 64);
    end
    bad = 0;
    foreach (hs_q[i]) if (hs_q[i].op != 3'd0 || hs_q[i].dirty0 != 2'b11) bad++;
    chk("t4_all_write", bad, 0);

    // Zero-length burst
    start_burst(2'd1, 16'd0);
    chk("t5_done_now", done, 1);
    chk("t5_no_valid", valid, 0);
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_no_hs", hs_q.size(), 0);
    chk("t5_done_cyc", done_cyc, start_cyc + 1);

    // start_i pulses during RUN are ignored
    ready = 1'b0;
    start_burst(2'd1, 16'd3);
    mode = 2'd0; num_req = 16'd1; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    ready = 1'b1;
    wait_done("t6_done_seen", 20);
    repeat (3) tick();
    chk("t6_count", hs_q.size(), 3);
    bad = 0;
    foreach (hs_q[i]) if (hs_q[i].op != 3'd1) bad++;
    chk("t6_all_read", bad, 0);
    chk("t6_idle", busy, 0);

    // Reset after 2 of 5 handshakes
    start_burst(2'd1, 16'd5);
    tick();
    tick();
    chk("t7_hs_before_rst", hs_q.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("t7_valid_low", valid, 0);
    chk("t7_busy_low", busy, 0);
    tick();
    tick();
    chk("t7_no_done", done_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("t7_still_no_done", done_cnt, 0);
    start_burst(2'd1, 16'd2);
    wait_done("t7_done_seen", 20);
    chk("t7_count", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      chk("t7_hs0_ch", hs_q[0].ch, 0);
      chk("t7_hs0_swo", hs_q[0].swo, 0);
      chk("t7_hs0_rob", hs_q[0].rob, 0);
      chk("t7_hs1_swo", hs_q[1].swo, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
